// File: rtl/commit_trace_tx.sv
// commit_trace_tx - commit-event recorder with FIFO-buffered valid/ready trace stream and halt drain.
// Optional macro TRACE_TIMESTAMP_EN appends the push-cycle cycle_count to every record.
module commit_trace_tx #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 32,
`ifdef TRACE_TIMESTAMP_EN
   localparam int REC_W = 72 + CNT_W
`else
   localparam int REC_W = 72
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      ev_pc,
   input  logic             ev_reg_wr,
   input  logic [3:0]       ev_reg_addr,
   input  logic [15:0]      ev_reg_data,
   input  logic             ev_mem_rd,
   input  logic             ev_mem_wr,
   input  logic [15:0]      ev_mem_addr,
   input  logic [15:0]      ev_mem_data,
   input  logic             ev_halt,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic [REC_W-1:0] tx_data,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] inst_count,
   output logic [CNT_W-1:0] drop_count,
   output logic             overflow,
   output logic             done
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

   state_e           state_q, state_d;
   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cycle_q, cycle_d, inst_q, inst_d, drop_q, drop_d;
   logic             ovf_q, ovf_d;
   logic [REC_W-1:0] mem_q [DEPTH];

   logic        empty, full, ev_any, mem_any, push, pop, drop;
   logic [71:0] rec_base;
   logic [REC_W-1:0] rec_w;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign ev_any  = ev_reg_wr | ev_mem_rd | ev_mem_wr | ev_halt;
   assign mem_any = ev_mem_rd | ev_mem_wr;
   assign pop     = !empty && tx_ready;
   assign push    = (state_q == RUN) && ev_any && (!full || pop);
   assign drop    = (state_q == RUN) && ev_any && !push;

   // Fields belonging to an inactive flag are zeroed so the sink sees clean records.
   assign rec_base = {ev_halt, ev_mem_wr, ev_mem_rd, ev_reg_wr, ev_pc,
                      ev_reg_wr ? ev_reg_addr : 4'h0,
                      ev_reg_wr ? ev_reg_data : 16'h0,
                      mem_any   ? ev_mem_addr : 16'h0,
                      mem_any   ? ev_mem_data : 16'h0};
`ifdef TRACE_TIMESTAMP_EN
   assign rec_w = {rec_base, cycle_q};
`else
   assign rec_w = rec_base;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cycle_d  = cycle_q;
      inst_d   = inst_q;
      drop_d   = drop_q;
      ovf_d    = ovf_q;
      state_d  = state_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         inst_d   = inst_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (drop) begin
         ovf_d = 1'b1;
         if (drop_q != {CNT_W{1'b1}}) drop_d = drop_q + 1'b1;
      end
      if (state_q != DONE) cycle_d = cycle_q + 1'b1;
      case (state_q)
         RUN:     if (ev_halt) state_d = DRAIN;
         DRAIN:   if (wr_ptr_d == rd_ptr_d) state_d = DONE;
         default: state_d = DONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cycle_q  <= '0;
         inst_q   <= '0;
         drop_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cycle_q  <= cycle_d;
         inst_q   <= inst_d;
         drop_q   <= drop_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_ptr_q[AW-1:0]] <= rec_w;
   end

   assign tx_valid    = !empty;
   assign tx_data     = mem_q[rd_ptr_q[AW-1:0]];
   assign cycle_count = cycle_q;
   assign inst_count  = inst_q;
   assign drop_count  = drop_q;
   assign overflow    = ovf_q;
   assign done        = (state_q == DONE);

endmodule

// File: tb/tb_commit_trace_tx.sv
// tb/tb_commit_trace_tx.sv - scoreboard bench for commit_trace_tx (default build, DEPTH=8).
module tb_commit_trace_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ev_pc, ev_reg_data, ev_mem_addr, ev_mem_data;
   logic [3:0]  ev_reg_addr;
   logic        ev_reg_wr, ev_mem_rd, ev_mem_wr, ev_halt;
   logic        tx_valid, tx_ready;
   logic [71:0] tx_data;
   logic [31:0] cycle_count, inst_count, drop_count;
   logic        overflow, done;

   int n_checks = 0;
   int n_fail   = 0;
   int n_sent   = 0;
   logic [71:0] sb_q[$];

   commit_trace_tx #(.DEPTH(8), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .ev_pc(ev_pc), .ev_reg_wr(ev_reg_wr), .ev_reg_addr(ev_reg_addr),
      .ev_reg_data(ev_reg_data), .ev_mem_rd(ev_mem_rd), .ev_mem_wr(ev_mem_wr),
      .ev_mem_addr(ev_mem_addr), .ev_mem_data(ev_mem_data), .ev_halt(ev_halt),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .cycle_count(cycle_count), .inst_count(inst_count), .drop_count(drop_count),
      .overflow(overflow), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [71:0] rec(input logic [3:0] f, input logic [15:0] pc, input logic [3:0] ra,
                                       input logic [15:0] rd, input logic [15:0] ma, input logic [15:0] md);
      return {f, pc, ra, rd, ma, md};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ev(input logic [3:0] f, input logic [15:0] pc, input logic [3:0] ra,
                     input logic [15:0] rd, input logic [15:0] ma, input logic [15:0] md);
      {ev_halt, ev_mem_wr, ev_mem_rd, ev_reg_wr} = f;
      ev_pc = pc; ev_reg_addr = ra; ev_reg_data = rd; ev_mem_addr = ma; ev_mem_data = md;
   endtask

   task automatic idle();
      ev(4'b0000, 16'h0, 4'h0, 16'h0, 16'h0, 16'h0);
   endtask

   // Monitor: every accepted beat must match the oldest expected record.
   always @(negedge clk) begin
      if (!rst && tx_valid && tx_ready) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_record: got %0h expected none", tx_data);
         end else begin
            logic [71:0] e;
            e = sb_q.pop_front();
            if (tx_data !== e) begin
               n_fail++;
               $display("FAIL record_%0d: got %0h expected %0h", n_sent, tx_data, e);
            end
         end
         n_sent++;
      end
   end

   initial begin
      int base;
      logic [31:0] c_frozen;
      rst = 1'b1; tx_ready = 1'b0; idle();
      tick(); tick();
      check("rst_tx_valid", tx_valid, 0);
      check("rst_cycle", cycle_count, 0);
      check("rst_inst", inst_count, 0);
      check("rst_drop", drop_count, 0);
      check("rst_ovf", overflow, 0);
      check("rst_done", done, 0);
      rst = 1'b0;

      // 1: single reg write, memory fields driven with junk must be zeroed
      tx_ready = 1'b1;
      ev(4'b0001, 16'h0010, 4'h3, 16'h1234, 16'hAAAA, 16'h5555);
      sb_q.push_back(72'h1_0010_3_1234_0000_0000);
      tick(); idle();
      check("t1_valid", tx_valid, 1);
      check("t1_inst", inst_count, 1);
      tick();

      // 2: load gives exactly one record with reg_wr and mem_rd
      ev(4'b0011, 16'h0012, 4'h5, 16'hBEEF, 16'h0040, 16'hBEEF);
      sb_q.push_back(72'h3_0012_5_BEEF_0040_BEEF);
      tick(); idle();
      check("t2_inst", inst_count, 2);
      tick();
      check("t2_drained", tx_valid, 0);

      // 3: overflow with ten stores into an eight-deep FIFO
      tx_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ev(4'b0100, 16'h0100 + 16'(i), 4'hF, 16'hFFFF, 16'h0200 + 16'(i), 16'h3000 + 16'(i));
         if (i < 8) sb_q.push_back(rec(4'b0100, 16'h0100 + 16'(i), 4'h0, 16'h0, 16'h0200 + 16'(i), 16'h3000 + 16'(i)));
         tick();
      end
      idle();
      check("t3_drop", drop_count, 2);
      check("t3_ovf", overflow, 1);
      check("t3_inst", inst_count, 10);
      check("t3_valid", tx_valid, 1);

      // 4: push and pop together while full: no drop, new record comes out last
      base = n_sent;
      tx_ready = 1'b1;
      ev(4'b0001, 16'h0400, 4'h7, 16'h7777, 16'h1111, 16'h2222);
      sb_q.push_back(72'h1_0400_7_7777_0000_0000);
      tick(); idle();
      check("t4_drop", drop_count, 2);
      check("t4_inst", inst_count, 11);
      for (int k = 0; k < 20 && tx_valid; k++) tick();
      check("t4_sent", n_sent - base, 9);
      check("t4_stopped", tx_valid, 0);
      check("t4_sb_empty", sb_q.size(), 0);

      // 5: three records, halt, then ignored events during drain
      tx_ready = 1'b0;
      base = n_sent;
      for (int i = 0; i < 3; i++) begin
         ev(4'b0001, 16'h0500 + 16'(i), 4'(i), 16'h5000 + 16'(i), 16'h0, 16'h0);
         sb_q.push_back(rec(4'b0001, 16'h0500 + 16'(i), 4'(i), 16'h5000 + 16'(i), 16'h0, 16'h0));
         tick();
      end
      ev(4'b1000, 16'h0600, 4'h9, 16'h9999, 16'h8888, 16'h7777);
      sb_q.push_back(72'h8_0600_0_0000_0000_0000);
      tick();
      tx_ready = 1'b1;
      ev(4'b0101, 16'h0700, 4'h1, 16'h0701, 16'h0702, 16'h0703);
      for (int k = 0; k < 20 && !done; k++) tick();
      check("t5_done", done, 1);
      check("t5_valid", tx_valid, 0);
      check("t5_sent", n_sent - base, 4);
      check("t5_inst", inst_count, 15);
      check("t5_drop", drop_count, 2);
      c_frozen = cycle_count;
      tick(); tick(); tick();
      check("t5_cycle_frozen", cycle_count, c_frozen);
      check("t5_still_done", done, 1);
      check("t5_inst_ignored", inst_count, 15);

      // 6: reset with five records queued flushes everything
      rst = 1'b1; idle(); tick(); rst = 1'b0;
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ev(4'b0001, 16'h0800 + 16'(i), 4'h2, 16'h0022, 16'h0, 16'h0);
         tick();
      end
      check("t6_pre_inst", inst_count, 5);
      check("t6_pre_valid", tx_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0; idle();
      check("t6_valid", tx_valid, 0);
      check("t6_inst", inst_count, 0);
      check("t6_cycle", cycle_count, 0);
      check("t6_drop", drop_count, 0);
      check("t6_ovf", overflow, 0);
      check("t6_done", done, 0);

      // stream restarts cleanly after reset
      tx_ready = 1'b1;
      ev(4'b0001, 16'h0900, 4'hA, 16'hCAFE, 16'h0, 16'h0);
      sb_q.push_back(72'h1_0900_A_CAFE_0000_0000);
      tick(); idle();
      check("t6_restart_inst", inst_count, 1);
      tick(); tick();
      check("final_sb_empty", sb_q.size(), 0);
      check("final_valid", tx_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
